// File: rtl/alu_exec_pipe_pkg.sv
// alu_exec_pipe_pkg: shared ALU opcodes, core sizing constants and the recall range test.
package alu_exec_pipe_pkg;
  localparam int AL_SIZE = 32;
  localparam int AL_W = $clog2(AL_SIZE);
  localparam int PREG_W = 6;
  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_SLL  = 4'd2,
    OP_SLT  = 4'd3,
    OP_SLTU = 4'd4,
    OP_XOR  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_OR   = 4'd8,
    OP_AND  = 4'd9
  } alu_op_e;
  function automatic logic [AL_W:0] al_dist(input logic [AL_W-1:0] x, input logic [AL_W-1:0] base);
    return (x >= base) ? {1'b0, x} - {1'b0, base}
                       : {1'b0, x} + (AL_W+1)'(AL_SIZE) - {1'b0, base};
  endfunction
  // Modular distance test, so new_front==back yields an empty range.
  function automatic logic in_range(input logic [AL_W-1:0] x, input logic [AL_W-1:0] new_front,
                                    input logic [AL_W-1:0] back);
    return al_dist(x, new_front) < al_dist(back, new_front);
  endfunction
endpackage

// File: rtl/alu_wb_fifo.sv
// alu_wb_fifo: result buffer with per-entry live bits, recall squashing and dead-head auto-pop.
module alu_wb_fifo #(
  parameter int DEPTH  = 2,
  parameter int PREG_W = alu_exec_pipe_pkg::PREG_W
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             push,
  input  logic [PREG_W-1:0]                push_prd,
  input  logic [31:0]                      push_data,
  input  logic [alu_exec_pipe_pkg::AL_W-1:0] push_al,
  input  logic                             recall,
  input  logic [alu_exec_pipe_pkg::AL_W-1:0] new_front,
  input  logic [alu_exec_pipe_pkg::AL_W-1:0] back,
  input  logic                             wb_ready,
  output logic                             wb_valid,
  output logic [PREG_W-1:0]                wb_prd,
  output logic [31:0]                      wb_data,
  output logic [alu_exec_pipe_pkg::AL_W-1:0] wb_al_idx,
  output logic [$clog2(DEPTH):0]           count
);
  import alu_exec_pipe_pkg::*;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [PREG_W-1:0] prd_q [DEPTH];
  logic [31:0] data_q [DEPTH];
  logic [AL_W-1:0] al_q [DEPTH];
  logic [DEPTH-1:0] live_q;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic not_empty, pop;
  assign not_empty = count != '0;
  assign wb_valid = not_empty && live_q[rd_ptr];
  // Dead heads leave without waiting for the writeback network.
  assign pop = not_empty && (!live_q[rd_ptr] || wb_ready);
  assign wb_prd = prd_q[rd_ptr];
  assign wb_data = data_q[rd_ptr];
  assign wb_al_idx = al_q[rd_ptr];
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        prd_q[i] <= '0;
        data_q[i] <= '0;
        al_q[i] <= '0;
      end
      live_q <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (recall && in_range(al_q[i], new_front, back)) live_q[i] <= 1'b0;
      if (push) begin
        prd_q[wr_ptr] <= push_prd;
        data_q[wr_ptr] <= push_data;
        al_q[wr_ptr] <= push_al;
        live_q[wr_ptr] <= 1'b1;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: rtl/alu_exec_pipe.sv
// alu_exec_pipe: single-cycle integer ALU stage feeding a recall-aware writeback buffer.
module alu_exec_pipe #(
  parameter int PREG_W     = alu_exec_pipe_pkg::PREG_W,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             iq_valid,
  output logic                             iq_ready,
  input  logic [3:0]                       iq_op,
  input  logic [31:0]                      iq_a,
  input  logic [31:0]                      iq_b,
  input  logic [PREG_W-1:0]                iq_prd,
  input  logic [alu_exec_pipe_pkg::AL_W-1:0] iq_al_idx,
  input  logic                             if_recall,
  input  logic [alu_exec_pipe_pkg::AL_W-1:0] new_front,
  input  logic [alu_exec_pipe_pkg::AL_W-1:0] back,
  output logic                             wb_valid,
  input  logic                             wb_ready,
  output logic [PREG_W-1:0]                wb_prd,
  output logic [31:0]                      wb_data,
  output logic [alu_exec_pipe_pkg::AL_W-1:0] wb_al_idx
);
  import alu_exec_pipe_pkg::*;
  logic e_valid;
  logic [3:0] e_op;
  logic [31:0] e_a, e_b, alu_res;
  logic [PREG_W-1:0] e_prd;
  logic [AL_W-1:0] e_al;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic take, push;
  // Counting the E slot guarantees every accepted op has a FIFO slot waiting for it.
  assign iq_ready = (int'(fifo_count) + int'(e_valid)) < FIFO_DEPTH;
  assign take = iq_valid && iq_ready && !(if_recall && in_range(iq_al_idx, new_front, back));
  assign push = e_valid && !(if_recall && in_range(e_al, new_front, back));
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_valid <= 1'b0;
      e_op <= '0;
      e_a <= '0;
      e_b <= '0;
      e_prd <= '0;
      e_al <= '0;
    end else begin
      e_valid <= take;
      if (take) begin
        e_op <= iq_op;
        e_a <= iq_a;
        e_b <= iq_b;
        e_prd <= iq_prd;
        e_al <= iq_al_idx;
      end
    end
  end
  always_comb begin
    alu_res = '0;
    case (e_op)
      OP_ADD:  alu_res = e_a + e_b;
      OP_SUB:  alu_res = e_a - e_b;
      OP_SLL:  alu_res = e_a << e_b[4:0];
      OP_SLT:  alu_res = {31'b0, $signed(e_a) < $signed(e_b)};
      OP_SLTU: alu_res = {31'b0, e_a < e_b};
      OP_XOR:  alu_res = e_a ^ e_b;
      OP_SRL:  alu_res = e_a >> e_b[4:0];
      OP_SRA:  alu_res = $signed(e_a) >>> e_b[4:0];
      OP_OR:   alu_res = e_a | e_b;
      OP_AND:  alu_res = e_a & e_b;
      default: alu_res = '0;
    endcase
  end
  alu_wb_fifo #(.DEPTH(FIFO_DEPTH), .PREG_W(PREG_W)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .push_prd(e_prd),
    .push_data(alu_res),
    .push_al(e_al),
    .recall(if_recall),
    .new_front(new_front),
    .back(back),
    .wb_ready(wb_ready),
    .wb_valid(wb_valid),
    .wb_prd(wb_prd),
    .wb_data(wb_data),
    .wb_al_idx(wb_al_idx),
    .count(fifo_count)
  );
endmodule

// File: tb/tb_alu_exec_pipe.sv
// tb_alu_exec_pipe: directed vector table for the ALU plus hand-written back-pressure/recall/reset sequences.
module tb_alu_exec_pipe;
  import alu_exec_pipe_pkg::*;
  typedef struct {
    logic [3:0] op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic [5:0] prd;
    logic [4:0] al;
  } vec_t;
  logic clk, reset, iq_valid, iq_ready, if_recall, wb_valid, wb_ready;
  logic [3:0] iq_op;
  logic [31:0] iq_a, iq_b, wb_data;
  logic [5:0] iq_prd, wb_prd;
  logic [4:0] iq_al_idx, new_front, back, wb_al_idx;
  int checks = 0, errors = 0;
  vec_t vecs[12];
  logic [31:0] got_data[$];
  logic [4:0] got_al[$];
  alu_exec_pipe #(.PREG_W(6), .FIFO_DEPTH(2)) dut (
    .clk(clk), .reset(reset), .iq_valid(iq_valid), .iq_ready(iq_ready), .iq_op(iq_op),
    .iq_a(iq_a), .iq_b(iq_b), .iq_prd(iq_prd), .iq_al_idx(iq_al_idx), .if_recall(if_recall),
    .new_front(new_front), .back(back), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_prd(wb_prd), .wb_data(wb_data), .wb_al_idx(wb_al_idx)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask
  task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [5:0] prd, input logic [4:0] al);
    iq_valid = v;
    iq_op = op;
    iq_a = a;
    iq_b = b;
    iq_prd = prd;
    iq_al_idx = al;
  endtask
  task automatic recall(input logic r, input logic [4:0] nf, input logic [4:0] bk);
    if_recall = r;
    new_front = nf;
    back = bk;
  endtask
  task automatic collect(input int n);
    got_data.delete();
    got_al.delete();
    wb_ready = 1'b1;
    repeat (n) begin
      if (wb_valid) begin
        got_data.push_back(wb_data);
        got_al.push_back(wb_al_idx);
      end
      cyc();
    end
    wb_ready = 1'b0;
  endtask
  task automatic fill2(input logic [4:0] al0, input logic [4:0] al1);
    wb_ready = 1'b0;
    drive(1'b1, OP_ADD, 32'(al0), 32'd0, 6'd1, al0);
    cyc();
    drive(1'b1, OP_ADD, 32'(al1), 32'd0, 6'd2, al1);
    cyc();
    drive(1'b0, OP_ADD, 32'd0, 32'd0, 6'd0, 5'd0);
    cyc();
  endtask
  initial begin
    int k;
    logic rdy;
    vecs[0]  = '{OP_ADD,  32'd7,         32'hFFFF_FFFF, 32'd6,         6'd5,  5'd3};
    vecs[1]  = '{OP_SUB,  32'd0,         32'd1,         32'hFFFF_FFFF, 6'd6,  5'd4};
    vecs[2]  = '{OP_SLL,  32'd1,         32'd35,        32'd8,         6'd7,  5'd5};
    vecs[3]  = '{OP_SLT,  32'hFFFF_FFFF, 32'd1,         32'd1,         6'd8,  5'd6};
    vecs[4]  = '{OP_SLTU, 32'hFFFF_FFFF, 32'd1,         32'd0,         6'd9,  5'd7};
    vecs[5]  = '{OP_XOR,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 6'd10, 5'd8};
    vecs[6]  = '{OP_SRL,  32'h8000_0000, 32'd31,        32'd1,         6'd11, 5'd9};
    vecs[7]  = '{OP_SRA,  32'h8000_0000, 32'd31,        32'hFFFF_FFFF, 6'd12, 5'd10};
    vecs[8]  = '{OP_OR,   32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 6'd13, 5'd11};
    vecs[9]  = '{OP_AND,  32'hFFFF_0000, 32'h1234_5678, 32'h1234_0000, 6'd14, 5'd12};
    vecs[10] = '{4'd15,   32'd5,         32'd5,         32'd0,         6'd15, 5'd13};
    vecs[11] = '{OP_SLT,  32'd1,         32'hFFFF_FFFF, 32'd0,         6'd63, 5'd31};
    reset = 1'b0;
    wb_ready = 1'b0;
    drive(1'b0, OP_ADD, 32'd0, 32'd0, 6'd0, 5'd0);
    recall(1'b0, 5'd0, 5'd0);
    cyc();
    cyc();
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_wb_prd", 32'(wb_prd), 32'd0);
    chk("rst_wb_al", 32'(wb_al_idx), 32'd0);
    reset = 1'b1;
    cyc();
    chk("rst_iq_ready", 32'(iq_ready), 32'd1);
    // ALU vector table: accept, one stage of latency, result, then pop
    for (int i = 0; i < 12; i++) begin
      wb_ready = 1'b1;
      drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].prd, vecs[i].al);
      cyc();
      drive(1'b0, OP_ADD, 32'd0, 32'd0, 6'd0, 5'd0);
      chk($sformatf("v%0d_lat_valid", i), 32'(wb_valid), 32'd0);
      cyc();
      chk($sformatf("v%0d_valid", i), 32'(wb_valid), 32'd1);
      chk($sformatf("v%0d_data", i), wb_data, vecs[i].exp);
      chk($sformatf("v%0d_prd", i), 32'(wb_prd), 32'(vecs[i].prd));
      chk($sformatf("v%0d_al", i), 32'(wb_al_idx), 32'(vecs[i].al));
      cyc();
      chk($sformatf("v%0d_popped", i), 32'(wb_valid), 32'd0);
    end
    // Back-pressure: three ops offered back to back while writeback stalls
    wb_ready = 1'b0;
    k = 0;
    got_data.delete();
    for (int c = 0; c < 40 && !(k == 3 && got_data.size() == 3); c++) begin
      if (c == 8) wb_ready = 1'b1;
      drive(k < 3, OP_ADD, 32'(k), 32'd100, 6'(k + 20), 5'(k));
      if (c == 2) chk("bp_ready_low", 32'(iq_ready), 32'd0);
      if (c == 6) chk("bp_accepts_stalled", 32'(k), 32'd2);
      rdy = iq_ready;
      if (wb_valid && wb_ready) got_data.push_back(wb_data);
      cyc();
      if (rdy && iq_valid) k++;
    end
    drive(1'b0, OP_ADD, 32'd0, 32'd0, 6'd0, 5'd0);
    repeat (3) begin
      if (wb_valid && wb_ready) got_data.push_back(wb_data);
      cyc();
    end
    wb_ready = 1'b0;
    chk("bp_accepted", 32'(k), 32'd3);
    chk("bp_count", 32'(got_data.size()), 32'd3);
    for (int j = 0; j < 3 && j < got_data.size(); j++)
      chk($sformatf("bp_order%0d", j), got_data[j], 32'(100 + j));
    // Wrapping recall: al30 in FIFO survives, al31 in E and incoming al0 are squashed
    wb_ready = 1'b0;
    drive(1'b1, OP_ADD, 32'd30, 32'd0, 6'd1, 5'd30);
    cyc();
    drive(1'b1, OP_ADD, 32'd31, 32'd0, 6'd2, 5'd31);
    cyc();
    drive(1'b1, OP_ADD, 32'd0, 32'd0, 6'd3, 5'd0);
    recall(1'b1, 5'd31, 5'd2);
    cyc();
    recall(1'b0, 5'd0, 5'd0);
    drive(1'b0, OP_ADD, 32'd0, 32'd0, 6'd0, 5'd0);
    chk("rc_head_valid", 32'(wb_valid), 32'd1);
    chk("rc_head_al", 32'(wb_al_idx), 32'd30);
    collect(6);
    chk("rc_count", 32'(got_al.size()), 32'd1);
    if (got_al.size() > 0) chk("rc_al", 32'(got_al[0]), 32'd30);
    // Incoming op in range is dropped; one just past back is kept
    drive(1'b1, OP_ADD, 32'd9, 32'd9, 6'd4, 5'd1);
    recall(1'b1, 5'd31, 5'd2);
    chk("drop_ready", 32'(iq_ready), 32'd1);
    cyc();
    drive(1'b1, OP_ADD, 32'd2, 32'd2, 6'd5, 5'd2);
    cyc();
    recall(1'b0, 5'd0, 5'd0);
    drive(1'b0, OP_ADD, 32'd0, 32'd0, 6'd0, 5'd0);
    collect(6);
    chk("drop_count", 32'(got_al.size()), 32'd1);
    if (got_al.size() > 0) chk("drop_kept_al", 32'(got_al[0]), 32'd2);
    if (got_data.size() > 0) chk("drop_kept_data", got_data[0], 32'd4);
    // Dead head is auto-popped without wb_ready
    fill2(5'd10, 5'd11);
    chk("dh_head", 32'(wb_al_idx), 32'd10);
    recall(1'b1, 5'd10, 5'd11);
    cyc();
    recall(1'b0, 5'd0, 5'd0);
    chk("dh_dead_hidden", 32'(wb_valid), 32'd0);
    cyc();
    chk("dh_next_valid", 32'(wb_valid), 32'd1);
    chk("dh_next_al", 32'(wb_al_idx), 32'd11);
    collect(4);
    chk("dh_count", 32'(got_al.size()), 32'd1);
    // Empty recall range squashes nothing
    fill2(5'd10, 5'd11);
    recall(1'b1, 5'd10, 5'd10);
    cyc();
    recall(1'b0, 5'd0, 5'd0);
    collect(6);
    chk("er_count", 32'(got_al.size()), 32'd2);
    if (got_al.size() > 1) begin
      chk("er_al0", 32'(got_al[0]), 32'd10);
      chk("er_al1", 32'(got_al[1]), 32'd11);
    end
    // Reset while FIFO is full
    fill2(5'd20, 5'd21);
    chk("rs_full_valid", 32'(wb_valid), 32'd1);
    chk("rs_full_ready", 32'(iq_ready), 32'd0);
    reset = 1'b0;
    #1;
    chk("rs_async_valid", 32'(wb_valid), 32'd0);
    chk("rs_async_data", wb_data, 32'd0);
    cyc();
    reset = 1'b1;
    cyc();
    chk("rs_rel_ready", 32'(iq_ready), 32'd1);
    chk("rs_rel_valid", 32'(wb_valid), 32'd0);
    collect(4);
    chk("rs_no_stale", 32'(got_al.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_exec_pipe.md
Name: alu_exec_pipe

Overview:
- Consumes the instruction issued by one arithmetic issue-queue bank.
- Executes it on a single-cycle integer ALU.
- Buffers the result in a small FIFO until the writeback network accepts it.
- One instance sits downstream of each bank. It provides back-pressure to the bank through iq_ready and honours branch recall by squashing in-flight work.

Parameters:
AL_SIZE, `AL_SIZE, active-list entries; AL_W = $clog2(AL_SIZE)
PREG_W, 6, physical register tag width
FIFO_DEPTH, 2, result buffer entries (power of 2, >=2)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low (0 = in reset)
iq_valid  in  1  issued op present
iq_ready  out  1  pipe can accept this cycle
iq_op  in  4  alu_op_e
iq_a  in  32  operand A value
iq_b  in  32  operand B value
iq_prd  in  PREG_W  destination physical register
iq_al_idx  in  AL_W  active-list index
if_recall  in  1  recall strobe
new_front  in  AL_W  first squashed AL index
back  in  AL_W  AL tail (exclusive)
wb_valid  out  1  result available
wb_ready  in  1  writeback accepts
wb_prd  out  PREG_W  result tag
wb_data  out  32  result value
wb_al_idx  out  AL_W  result AL index

Behaviour:
- Reset: E stage invalid, FIFO empty, wb_valid=0, wb_prd/wb_data/wb_al_idx=0. iq_ready=1 once reset releases.
- Accept: a transfer occurs on a rising edge when iq_valid && iq_ready.
- iq_ready = (fifo_count + e_valid) < FIFO_DEPTH. It is registered-state only, with no combinational path from wb_ready or iq_valid.
- Stage E register captures op, a, b, prd and al_idx on accept. e_valid is cleared when there is no accept.
- ALU result is computed combinationally from E:
  - ADD, SUB: 32-bit wrap.
  - SLL, SRL, SRA: shift by b[4:0].
  - SLT: signed compare. SLTU: unsigned compare. Both give 0/1 zero-extended.
  - XOR, OR, AND.
  - Undefined encodings give 0.
- The E result is pushed into the FIFO on the next edge. Latency: accept at edge t, wb_valid high after edge t+1.
- The FIFO head drives the wb_* outputs. Pop happens on wb_valid && wb_ready. Push and pop in the same cycle are allowed, and the count is unchanged.
- Recall: in_range(x) = ((x - new_front) mod AL_SIZE) < ((back - new_front) mod AL_SIZE). new_front==back means an empty range.
  - When if_recall=1, every E entry and FIFO entry with in_range(al_idx) is marked dead on that edge.
  - An incoming iq op with in_range(iq_al_idx) is dropped. iq_ready is unaffected.
- Dead entries keep their FIFO slot.
  - wb_valid = head_live.
  - A dead head is popped automatically without wb_ready.
  - A dead E entry is not pushed.
- Recall coincident with a pop of a live head: the pop completes and the result is delivered, because the head is outside the range by construction (older than new_front).
- Pointers wrap modulo FIFO_DEPTH. fifo_count is ($clog2(FIFO_DEPTH)+1) bits wide.
- Reset asserted mid-operation clears all state immediately. No partial writeback is emitted.

Decomposition:
- Shared package (riscv_core.svh):
  - alu_op_e enum: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9.
  - `AL_SIZE and PREG_W constants.
  - in_range recall function, shared with the AIQ and active list.
- Sub-module alu_wb_fifo holds the FIFO entries, live bits, recall marking and dead-head auto-pop. The ALU stays inline.

Test Plan:
- Single op: ADD a=7, b=0xFFFFFFFF, prd=5, al=3 -> wb_valid after 2 edges, wb_data=6, wb_prd=5, wb_al_idx=3.
- Back-pressure: wb_ready=0 with 3 back-to-back valid ops.
  - iq_ready drops after 2 accepts. No op is lost or duplicated.
  - Raising wb_ready drains results in order.
- Arithmetic corners:
  - SRA 0x80000000 by 31 -> 0xFFFFFFFF.
  - SLT 0xFFFFFFFF,1 -> 1.
  - SLTU 0xFFFFFFFF,1 -> 0.
  - SUB 0,1 -> 0xFFFFFFFF.
- Recall with AL_SIZE=32, al idx 30 (FIFO), 31 (E) and 0 (incoming), new_front=31, back=2 (wrap) -> only al 30 is written back, then empty.
- Recall with empty range (new_front=back=10) while entries are in flight -> nothing squashed, all results delivered.
- Reset driven low while FIFO is full -> wb_valid=0 immediately. iq_ready=1 once reset returns high. No stale result appears.
